// File: rtl/seq_detect_multi_ones_if.sv
// Serial detector link: c is the sampled data bit, d the registered detect flag.
// No handshake on this link; d changes only on clock edges.
interface seq_detect_multi_ones_if;
  logic c;
  logic d;

  modport master (output c, input d);
  modport slave (input c, output d);
endinterface

// File: rtl/seq_detect_multi_ones.sv
// Run detector: d=1 while the current run of 1s on c is >= MIN_ONES, one cycle after the qualifying edge.
// No backpressure; c is sampled every rising edge and d never depends combinationally on c.
module seq_detect_multi_ones #(
  parameter int unsigned MIN_ONES = 2,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  seq_detect_multi_ones_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COUNTING = 2'd1,
    DETECTED = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_ONES);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             d_q, d_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.c) begin
          cnt_d   = ONE_CNT;
          // A threshold of 1 (or less) detects on the very first 1.
          state_d = (MIN_CNT <= ONE_CNT) ? DETECTED : COUNTING;
        end
      end
      COUNTING: begin
        if (bus.c) begin
          cnt_d = cnt_q + ONE_CNT;
          if (cnt_d >= MIN_CNT) begin
            state_d = DETECTED;
          end
        end else begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      DETECTED: begin
        if (bus.c) begin
          // Hold at the threshold so an arbitrarily long run never wraps.
          cnt_d = MIN_CNT;
        end else begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
    d_d = (state_d == DETECTED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      d_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
    end
  end

  assign bus.d = d_q;

endmodule

// File: tb/tb_seq_detect_multi_ones.sv
// Randomised and directed bench for the run detector at thresholds 2 and 3, scoreboard-checked.
// Expected d comes from a run-length model; a monitor compares after every rising edge.
module tb_seq_detect_multi_ones;

  logic clk;
  logic reset;

  seq_detect_multi_ones_if bus2 ();
  seq_detect_multi_ones_if bus3 ();

  seq_detect_multi_ones #(.MIN_ONES(2), .CNT_W(8)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2.slave)
  );

  seq_detect_multi_ones #(.MIN_ONES(3), .CNT_W(8)) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bit exp2_q[$];
  bit exp3_q[$];
  int n_cmp  = 0;
  int n_err  = 0;
  int n_edge = 0;
  int run_len = 0;
  bit stim_done = 1'b0;

  // Reference: length of the current run of 1s; detection is run_len >= threshold.
  task automatic apply(input bit r, input bit cv);
    @(negedge clk);
    reset  = r;
    bus2.c = cv;
    bus3.c = cv;
    if (r) run_len = 0;
    else if (cv) run_len = run_len + 1;
    else run_len = 0;
    exp2_q.push_back(run_len >= 2);
    exp3_q.push_back(run_len >= 3);
  endtask

  task automatic apply_seq(input bit r, input int n, input bit cv);
    for (int i = 0; i < n; i++) apply(r, cv);
  endtask

  // Monitor: one expectation per sampled edge, compared 1ns after the edge.
  initial begin
    bit e;
    forever begin
      @(posedge clk);
      #1;
      n_edge++;
      if (exp2_q.size() > 0) begin
        e = exp2_q.pop_front();
        n_cmp++;
        if (bus2.d !== e) begin
          n_err++;
          $display("FAIL d_min2 edge %0d: got %b expected %b", n_edge, bus2.d, e);
        end
      end
      if (exp3_q.size() > 0) begin
        e = exp3_q.pop_front();
        n_cmp++;
        if (bus3.d !== e) begin
          n_err++;
          $display("FAIL d_min3 edge %0d: got %b expected %b", n_edge, bus3.d, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: stimulus did not complete, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset  = 1'b1;
    bus2.c = 1'b0;
    bus3.c = 1'b0;

    // Reset held for two edges.
    apply_seq(1'b1, 2, 1'b0);
    // Single 1 is not a detection.
    apply(1'b0, 1'b1);
    apply_seq(1'b0, 2, 1'b0);
    // Two 1s then a 0.
    apply_seq(1'b0, 2, 1'b1);
    apply(1'b0, 1'b0);
    // Long run: no glitch, no wrap.
    apply_seq(1'b0, 10, 1'b1);
    apply(1'b0, 1'b0);
    // Intervening 0s clear the count.
    apply(1'b0, 1'b1); apply(1'b0, 1'b0);
    apply(1'b0, 1'b1); apply(1'b0, 1'b0);
    apply(1'b0, 1'b1); apply(1'b0, 1'b1);
    apply(1'b0, 1'b0);
    // Reset mid-run with c held at 1.
    apply_seq(1'b0, 4, 1'b1);
    apply(1'b1, 1'b1);
    apply_seq(1'b0, 4, 1'b1);
    apply(1'b0, 1'b0);
    // Very long run (past 255 edges) to catch any counter wrap.
    apply_seq(1'b0, 300, 1'b1);
    apply(1'b0, 1'b0);

    for (int i = 0; i < 600; i++) begin
      apply(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0));
    end
    apply(1'b0, 1'b0);

    @(negedge clk);
    @(negedge clk);
    stim_done = 1'b1;
    n_cmp++;
    if (exp2_q.size() + exp3_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", exp2_q.size() + exp3_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_detect_multi_ones.md
Name: seq_detect_multi_ones

Overview:
- Serial bit-stream detector: asserts output d while the input c has been 1 on two or more consecutive clock edges, i.e. a run of "more than one 1".
- Moore-style FSM with a registered output, used as a small control/monitor block on a single-bit serial line.
- Single clock domain.
- The run-length threshold is parameterised; the default of 2 gives the "more than one 1" behaviour.

Parameters:
- MIN_ONES, 2, number of consecutive 1s (sampled on rising clk edges) required before d asserts. Legal range is 2..255.
- CNT_W, 8, width of the internal run counter. It must hold MIN_ONES.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- c  input  1  serial data bit, sampled on each rising clk edge.
- d  output  1  detect flag, registered; 1 while the current run of consecutive 1s has length >= MIN_ONES.

Behaviour:
- Reset: one clock; reset is synchronous and active-high.
  - On a rising clk edge with reset=1: the run counter goes to 0, the state goes to IDLE and d goes to 0.
  - reset has priority over c.
  - Before the first reset edge, state and d are undefined.
- States:
  - IDLE: the last sample was 0, or no sample has been taken since reset.
  - COUNTING: 1..MIN_ONES-1 consecutive 1s have been seen.
  - DETECTED: >= MIN_ONES consecutive 1s have been seen.
- Transitions, evaluated per rising edge with reset=0:
  - IDLE, c=1: counter becomes 1. Go to COUNTING, or to DETECTED if MIN_ONES==1 (not a legal value, but it must still behave sensibly).
  - IDLE, c=0: stay in IDLE.
  - COUNTING, c=1: counter increments. When the counter reaches MIN_ONES, go to DETECTED.
  - COUNTING, c=0: counter becomes 0, go to IDLE.
  - DETECTED, c=1: stay in DETECTED. The counter saturates at MIN_ONES and never wraps.
  - DETECTED, c=0: counter becomes 0, go to IDLE.
- Output:
  - d is a flop that equals (next state == DETECTED).
  - d rises on the same edge that samples the MIN_ONES-th consecutive 1, and is visible in the following cycle.
  - d falls on the edge that samples a 0.
  - d has no combinational path from c.
- Overlap: runs are overlapping. A continuous run of 1s keeps d high indefinitely; runs of any length are detected.
- Reset mid-run: counter and d are cleared on the reset edge. Counting restarts from 0 on the first edge after reset deasserts.

Test Plan:
- Apply reset=1 for 2 edges with c=0 -> d=0 after the first reset edge, and stays 0.
- Release reset, c=1 for 1 edge, then c=0 -> d stays 0 (a single 1 is not a detection).
- Release reset, c=1 on edges 1 and 2, then c=0 on edge 3 -> d=0 after edge 1, d=1 after edge 2, d=0 after edge 3.
- Drive c=1 for 10 consecutive edges -> d=1 from edge 2 through edge 10, with no glitches and no counter wrap (also run with MIN_ONES=3: d=1 from edge 3).
- Drive pattern 1,0,1,0,1,1 -> d=0 until the final edge, then d=1 (an intervening 0 clears the count).
- During a run with d=1, assert reset for 1 edge while c=1 -> d=0 on that edge. After release with c=1, d returns to 1 only after MIN_ONES further 1s.
